// File: rtl/ssr_fir_pkg.sv
// rtl/ssr_fir_pkg.sv - shared types and sizing helpers for the super-sample-rate FIR
package ssr_fir_pkg;

    typedef enum logic {IDLE, PENDING} coef_state_t;

    function automatic int acc_bits(input int nbits, input int cbits, input int ntaps);
        return nbits + cbits + $clog2(ntaps);
    endfunction

    function automatic int fir_latency(input int ntaps);
        return 3 + $clog2(ntaps);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int outbits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (outbits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ssr_fir_lane.sv
// rtl/ssr_fir_lane.sv - one output lane: registered products, registered adder tree, saturation
module ssr_fir_lane
    import ssr_fir_pkg::*;
#(
    parameter int NBITS   = 12,
    parameter int CBITS   = 4,
    parameter int NTAPS   = 42,
    parameter int OUTBITS = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NTAPS*NBITS-1:0]    x,
    input  logic [NTAPS*CBITS-1:0]    coefs,
    input  logic                      out_en,
    output logic signed [OUTBITS-1:0] dat,
    output logic                      sat
);

    localparam int LVL   = $clog2(NTAPS);
    localparam int LEAF  = 2 ** LVL;
    localparam int ACC   = acc_bits(NBITS, CBITS, NTAPS);
    localparam int PBITS = NBITS + CBITS;

    // Heap-ordered tree: node[1] is the root, leaves sit at node[LEAF+k].
    logic signed [ACC-1:0] node [1:2*LEAF-1];
    logic signed [ACC-1:0] prod_ext [LEAF];
    logic signed [63:0]    acc_wide;

    // x sample m is x[n-(NTAPS-1-m)], so tap k reads sample NTAPS-1-k.
    for (genvar k = 0; k < LEAF; k++) begin : g_prod
        if (k < NTAPS) begin : g_tap
            assign prod_ext[k] = ACC'(PBITS'($signed(coefs[CBITS*k +: CBITS])) *
                                      PBITS'($signed(x[NBITS*(NTAPS-1-k) +: NBITS])));
        end else begin : g_pad
            assign prod_ext[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 2*LEAF; i++) node[i] <= '0;
        end else begin
            for (int i = 1; i < LEAF; i++) node[i] <= node[2*i] + node[2*i+1];
            for (int k = 0; k < LEAF; k++) node[LEAF+k] <= prod_ext[k];
        end
    end

    assign acc_wide = 64'(node[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat <= '0;
            sat <= 1'b0;
        end else if (out_en) begin
            dat <= OUTBITS'(saturate(acc_wide, OUTBITS));
            sat <= (saturate(acc_wide, OUTBITS) != acc_wide);
        end else begin
            dat <= '0;
            sat <= 1'b0;
        end
    end

endmodule

// File: rtl/ssr_fir_filter.sv
// rtl/ssr_fir_filter.sv - super-sample-rate direct-form FIR with double-buffered coefficients
module ssr_fir_filter
    import ssr_fir_pkg::*;
#(
    parameter int NBITS   = 12,
    parameter int NSAMPS  = 8,
    parameter int NTAPS   = 42,
    parameter int CBITS   = 4,
    parameter int OUTBITS = 18
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NBITS*NSAMPS-1:0]     dat_i,
    input  logic                        dat_valid_i,
    input  logic                        coef_wr_i,
    input  logic [$clog2(NTAPS)-1:0]    coef_addr_i,
    input  logic [CBITS-1:0]            coef_dat_i,
    input  logic                        coef_commit_i,
    output logic                        coef_pending_o,
    output logic                        coef_err_o,
    output logic [OUTBITS*NSAMPS-1:0]   dat_o,
    output logic                        dat_valid_o,
    output logic                        sat_o
);

    localparam int LAT = fir_latency(NTAPS);
    localparam int HS  = NTAPS - 1;
    localparam int WS  = HS + NSAMPS;

    logic [NBITS*NSAMPS-1:0] in_dat;
    logic [LAT-1:0]          vpipe;
    logic [HS*NBITS-1:0]     hist;
    logic [WS*NBITS-1:0]     window;
    logic [NTAPS*CBITS-1:0]  shadow;
    logic [NTAPS*CBITS-1:0]  active;
    logic [NSAMPS-1:0]       lane_sat;
    coef_state_t             state;
    coef_state_t             state_next;
    logic                    wr_ok;
    logic                    wr_bad;
    logic                    swap;

    // History keeps exactly the NTAPS-1 most recent valid samples, oldest at bit 0.
    assign window = {in_dat, hist};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_dat <= '0;
            vpipe  <= '0;
            hist   <= '0;
        end else begin
            in_dat <= dat_i;
            vpipe  <= {vpipe[LAT-2:0], dat_valid_i};
            if (vpipe[0]) hist <= window[WS*NBITS-1 -: HS*NBITS];
        end
    end

    always_comb begin
        state_next = state;
        wr_ok      = 1'b0;
        wr_bad     = 1'b0;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (coef_wr_i) begin
                    if (32'(coef_addr_i) < NTAPS) wr_ok  = 1'b1;
                    else                          wr_bad = 1'b1;
                end
                if (coef_commit_i) state_next = PENDING;
            end
            PENDING: begin
                wr_bad = coef_wr_i;
                // The bank swaps on the edge that captures this beat, so the beat sees only new taps.
                if (dat_valid_i) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= '0;
            coef_err_o <= 1'b0;
        end else begin
            state      <= state_next;
            coef_err_o <= wr_bad;
            if (wr_ok) shadow[CBITS*coef_addr_i +: CBITS] <= coef_dat_i;
            if (swap)  active <= shadow;
        end
    end

    assign coef_pending_o = (state == PENDING);

    for (genvar i = 0; i < NSAMPS; i++) begin : g_lane
        ssr_fir_lane #(
            .NBITS  (NBITS),
            .CBITS  (CBITS),
            .NTAPS  (NTAPS),
            .OUTBITS(OUTBITS)
        ) u_lane (
            .clk   (aclk),
            .rst_n (aresetn),
            .x     (window[NBITS*i +: NTAPS*NBITS]),
            .coefs (active),
            .out_en(vpipe[LAT-2]),
            .dat   (dat_o[OUTBITS*i +: OUTBITS]),
            .sat   (lane_sat[i])
        );
    end

    assign dat_valid_o = vpipe[LAT-1];
    assign sat_o       = |lane_sat;

endmodule

// File: tb/tb_ssr_fir_filter.sv
// tb/tb_ssr_fir_filter.sv - directed self-checking bench for ssr_fir_filter
module tb_ssr_fir_filter;

    localparam int NB = 12, NS = 8, NT = 42, CB = 4, OB = 18, AW = 6, LAT = 9;
    localparam int SMAX = 131071, SMIN = -131072;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b1;
    logic [NB*NS-1:0]   dat_i = '0;
    logic               dat_valid_i = 1'b0;
    logic               coef_wr_i = 1'b0;
    logic [AW-1:0]      coef_addr_i = '0;
    logic [CB-1:0]      coef_dat_i = '0;
    logic               coef_commit_i = 1'b0;
    logic               coef_pending_o;
    logic               coef_err_o;
    logic [OB*NS-1:0]   dat_o;
    logic               dat_valid_o;
    logic               sat_o;

    int errors = 0, checks = 0, cyc = 0, nvi = 0, nvo = 0;
    int xs[$];
    int h_act[NT];
    int h_sh[NT];
    bit pend = 1'b0;
    int eq_dat[$];
    bit eq_sat[$];
    int eq_cyc[$];

    ssr_fir_filter #(.NBITS(NB), .NSAMPS(NS), .NTAPS(NT), .CBITS(CB), .OUTBITS(OB)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .dat_i         (dat_i),
        .dat_valid_i   (dat_valid_i),
        .coef_wr_i     (coef_wr_i),
        .coef_addr_i   (coef_addr_i),
        .coef_dat_i    (coef_dat_i),
        .coef_commit_i (coef_commit_i),
        .coef_pending_o(coef_pending_o),
        .coef_err_o    (coef_err_o),
        .dat_o         (dat_o),
        .dat_valid_o   (dat_valid_o),
        .sat_o         (sat_o)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn) begin
            if (dat_valid_o) begin
                nvo++;
                check("out_expected", eq_sat.size() > 0, 1);
                if (eq_sat.size() > 0) begin
                    check("latency", cyc - eq_cyc.pop_front(), LAT);
                    for (int i = 0; i < NS; i++)
                        check("lane", $signed(dat_o[OB*i +: OB]), eq_dat.pop_front());
                    check("sat", sat_o, eq_sat.pop_front());
                end
            end else begin
                check("sat_idle", sat_o, 0);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [NB*NS-1:0] d);
        int n, acc;
        bit s;
        if (pend) begin
            h_act = h_sh;
            pend  = 1'b0;
        end
        for (int i = 0; i < NS; i++) xs.push_back(int'($signed(d[NB*i +: NB])));
        s = 1'b0;
        for (int i = 0; i < NS; i++) begin
            n   = xs.size() - NS + i;
            acc = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0) acc += h_act[k] * xs[n-k];
            if (acc > SMAX) begin acc = SMAX; s = 1'b1; end
            if (acc < SMIN) begin acc = SMIN; s = 1'b1; end
            eq_dat.push_back(acc);
        end
        eq_sat.push_back(s);
        eq_cyc.push_back(cyc);
        dat_i       = d;
        dat_valid_i = 1'b1;
        nvi++;
        tick();
        dat_valid_i = 1'b0;
        check("pending_beat", coef_pending_o, pend);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            dat_i = {$urandom, $urandom, $urandom};
            tick();
        end
    endtask

    task automatic coef_op(input bit wr, input int addr, input int val, input bit cm);
        bit e;
        e = wr && (pend || addr >= NT);
        if (wr && !e) h_sh[addr] = val;
        if (cm && !pend) pend = 1'b1;
        coef_wr_i     = wr;
        coef_addr_i   = addr[AW-1:0];
        coef_dat_i    = val[CB-1:0];
        coef_commit_i = cm;
        tick();
        coef_wr_i     = 1'b0;
        coef_commit_i = 1'b0;
        check("coef_err", coef_err_o, e);
        check("pending", coef_pending_o, pend);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        xs.delete();
        eq_dat.delete();
        eq_sat.delete();
        eq_cyc.delete();
        for (int k = 0; k < NT; k++) begin h_act[k] = 0; h_sh[k] = 0; end
        pend = 1'b0;
        nvi  = 0;
        nvo  = 0;
        #1;
        check("rst_valid", dat_valid_o, 0);
        check("rst_dat", |dat_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_pending", coef_pending_o, 0);
        tick();
        aresetn = 1'b1;
    endtask

    function automatic logic [NB*NS-1:0] fill(input int v);
        logic [NB*NS-1:0] d;
        for (int i = 0; i < NS; i++) d[NB*i +: NB] = v[NB-1:0];
        return d;
    endfunction

    initial begin
        logic [NB*NS-1:0] d;
        int v;
        #2;
        do_reset();
        check("rst_err", coef_err_o, 0);

        // Impulse response with taps at both ends of the filter
        coef_op(1, 0, 1, 0);
        coef_op(1, 1, -2, 0);
        coef_op(1, 41, 3, 1);
        idle(2);
        for (int j = 0; j < 14; j++) begin
            d = '0;
            if (j == 0) d[NB*3 +: NB] = 12'd100;
            beat(d);
            if (j == 8) begin
                check("imp_lane3", $signed(dat_o[OB*3 +: OB]), 100);
                check("imp_lane4", $signed(dat_o[OB*4 +: OB]), -200);
            end
            if (j == 13) check("imp_tail_lane4", $signed(dat_o[OB*4 +: OB]), 300);
        end
        idle(12);

        // Saturation in both directions
        for (int k = 0; k < NT; k++) coef_op(1, k, 7, k == NT - 1);
        for (int j = 0; j < 26; j++) begin
            beat(fill(j < 10 ? 2047 : -2048));
            if (j == 12) begin
                check("sat_pos", $signed(dat_o[0 +: OB]), SMAX);
                check("sat_pos_flag", sat_o, 1);
            end
            if (j == 25) begin
                check("sat_neg", $signed(dat_o[OB*7 +: OB]), SMIN);
                check("sat_neg_flag", sat_o, 1);
            end
        end
        idle(12);

        // Rejected address, then random taps and a gapped random stream
        coef_op(1, 42, 3, 0);
        coef_op(0, 0, 0, 0);
        for (int k = 0; k < NT; k++) coef_op(1, k, int'($urandom_range(0, 15)) - 8, k == NT - 1);
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < NS; i++) begin
                v = int'($urandom_range(0, 1000)) - 500;
                d[NB*i +: NB] = v[NB-1:0];
            end
            beat(d);
            idle(3);
        end
        idle(12);
        check("gap_drain", eq_sat.size(), 0);
        check("gap_count", nvo, nvi);

        // Atomic bank swap held off by invalid cycles
        do_reset();
        coef_op(1, 0, 1, 1);
        for (int j = 0; j < 2; j++) beat(fill(11 + j));
        coef_op(1, 0, 2, 0);
        coef_op(0, 0, 0, 1);
        for (int j = 0; j < 4; j++) coef_op(j == 1, 0, 5, 0);
        for (int j = 0; j < 3; j++) beat(fill(-30 + 7 * j));
        idle(12);
        check("swap_drain", eq_sat.size(), 0);
        check("swap_count", nvo, nvi);

        // Reset with beats in flight, then an impulse through cleared taps
        for (int j = 0; j < 5; j++) beat(fill(400 + j));
        coef_op(0, 0, 0, 1);
        do_reset();
        check("post_rst_valid", dat_valid_o, 0);
        for (int j = 0; j < 7; j++) begin
            d = '0;
            if (j == 0) d[NB*3 +: NB] = 12'd100;
            beat(d);
        end
        idle(12);
        check("final_drain", eq_sat.size(), 0);
        check("final_count", nvo, nvi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
